// File: rtl/stage2_fmap_streamer_pkg.sv
// Shared constants for the stage-2 fmap streamer (channel count, sample width, frame size, gap).
// STAGE2_STREAM_PINGPONG_EN selects two frame banks instead of one.
package stage2_fmap_streamer_pkg;

    localparam int ST2_CONV_CI    = 3;
    localparam int ST2_CONV_IBW   = 8;
    localparam int ST2_CONV_X     = 12;
    localparam int ST2_CONV_Y     = 12;
    localparam int ST2_STREAM_GAP = 8;

`ifdef STAGE2_STREAM_PINGPONG_EN
    localparam int ST2_STREAM_BANKS = 2;
`else
    localparam int ST2_STREAM_BANKS = 1;
`endif

    // With a single bank the bank pointer never leaves 0.
    function automatic logic bank_next(input logic bank);
        return (ST2_STREAM_BANKS == 2) ? ~bank : 1'b0;
    endfunction

endpackage

// File: rtl/stage2_fmap_streamer_bank.sv
// One frame bank: simple dual-port RAM with a single write port and a registered read port.
// Contents are never reset.
module stage2_fmap_bank
    import stage2_fmap_streamer_pkg::*;
#(
    parameter int W     = ST2_CONV_CI * ST2_CONV_IBW,
    parameter int DEPTH = ST2_CONV_X * ST2_CONV_Y,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stage2_fmap_streamer.sv
// Captures one pooled stage-1 fmap and replays it as a gap-free raster burst into the stage-2 core.
// STAGE2_STREAM_PINGPONG_EN (in the package) enables a second bank so capture overlaps streaming.
module stage2_fmap_streamer
    import stage2_fmap_streamer_pkg::*;
#(
    parameter int CI   = ST2_CONV_CI,
    parameter int IBW  = ST2_CONV_IBW,
    parameter int COLS = ST2_CONV_X,
    parameter int ROWS = ST2_CONV_Y,
    parameter int GAP  = ST2_STREAM_GAP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_valid,
    input  logic [CI*IBW-1:0] i_wr_fmap,
    output logic              o_wr_ready,
    input  logic              i_rd_en,
    output logic              o_ot_valid,
    output logic [CI*IBW-1:0] o_ot_fmap,
    output logic              o_frame_last,
    output logic              o_busy,
    output logic              o_ovf
);

    localparam int W   = CI * IBW;
    localparam int PIX = COLS * ROWS;
    localparam int AW  = $clog2(PIX);
    localparam int GW  = $clog2(GAP + 1);
    localparam int NB  = ST2_STREAM_BANKS;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PIX - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]    full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          wr_ready, wr_acc, wr_last, rd_issue, rd_last;
    logic          vld_p1_q, last_p1_q, sel_p1_q;
    logic          vld_p2_q, last_p2_q;
    logic [W-1:0]  fmap_p2_q;
    logic [W-1:0]  rd_data [2];

    assign wr_ready = ~full_q[wr_bank_q];
    assign wr_acc   = i_wr_valid & wr_ready;
    assign wr_last  = wr_acc & (wr_addr_q == LAST_ADDR);
    assign rd_issue = (state_q == S_STREAM);
    assign rd_last  = rd_issue & (rd_addr_q == LAST_ADDR);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NB) begin : g_ram
            stage2_fmap_bank #(.W(W), .DEPTH(PIX), .AW(AW)) u_bank (
                .clk     (clk),
                .we_i    (wr_acc && (wr_bank_q == 1'(b))),
                .waddr_i (wr_addr_q),
                .wdata_i (i_wr_fmap),
                .re_i    (rd_issue && (rd_bank_q == 1'(b))),
                .raddr_i (rd_addr_q),
                .rdata_o (rd_data[b])
            );
        end else begin : g_none
            assign rd_data[b] = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_bank_d = wr_bank_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        gap_cnt_d = gap_cnt_q;
        full_d    = full_q;
        ovf_d     = ovf_q | (i_wr_valid & ~wr_ready);

        if (wr_acc) begin
            wr_addr_d = wr_last ? '0 : wr_addr_q + 1'b1;
            if (wr_last) wr_bank_d = bank_next(wr_bank_q);
        end

        case (state_q)
            S_IDLE: begin
                rd_addr_d = '0;
                if (full_q[rd_bank_q] && i_rd_en) state_d = S_STREAM;
            end
            S_STREAM: begin
                rd_addr_d = rd_addr_q + 1'b1;
                if (rd_last) begin
                    state_d   = S_GAP;
                    rd_addr_d = '0;
                    rd_bank_d = bank_next(rd_bank_q);
                    // The IDLE decision cycle is the last idle cycle of the gap.
                    gap_cnt_d = GW'(GAP - 1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= GW'(1)) state_d = S_IDLE;
                else gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Release and fill always target different banks, so both can apply.
        if (rd_last) full_d[rd_bank_q] = 1'b0;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            wr_bank_q <= 1'b0;
            rd_addr_q <= '0;
            rd_bank_q <= 1'b0;
            gap_cnt_q <= '0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            sel_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            fmap_p2_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_bank_q <= wr_bank_d;
            rd_addr_q <= rd_addr_d;
            rd_bank_q <= rd_bank_d;
            gap_cnt_q <= gap_cnt_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            // p1: RAM read registered inside the bank
            vld_p1_q  <= rd_issue;
            last_p1_q <= rd_last;
            sel_p1_q  <= rd_bank_q;
            // p2: output register, data held while idle
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
            if (vld_p1_q) fmap_p2_q <= rd_data[sel_p1_q];
        end
    end

    assign o_wr_ready   = wr_ready;
    assign o_ot_valid   = vld_p2_q;
    assign o_ot_fmap    = fmap_p2_q;
    assign o_frame_last = last_p2_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_ovf        = ovf_q;

endmodule
